systolic_drain: RTL and testbench

- Consumer end of the array's result-ready interface.
- Snapshots the full ROWS x COLS accumulator result grid when the controller signals stream_out_rdy.
- Holds up to two snapshots in a ping-pong buffer and streams them out row by row over a valid/ready master interface.
- Drives stall back to the array/controller when both buffers are occupied, so no result set is lost.

---
 rtl/systolic_drain_pkg.sv | 33 +++
 rtl/systolic_drain_bank.sv | 37 +++
 rtl/systolic_drain.sv | 133 +++++++++++++
 tb/tb_systolic_drain.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_drain_pkg.sv
// Shared sizing helpers, default geometry and read-FSM state type for the systolic result drain.
package systolic_drain_pkg;

    localparam int unsigned DEF_OUT_WIDTH = 16;
    localparam int unsigned DEF_ROWS      = 4;
    localparam int unsigned DEF_COLS      = 4;

    localparam int unsigned ROW_W  = DEF_COLS * DEF_OUT_WIDTH;
    localparam int unsigned GRID_W = DEF_ROWS * ROW_W;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_state_e;

endpackage

// File: rtl/systolic_drain_bank.sv
// One snapshot of the accumulator grid: whole-grid load, row-select read.
module systolic_drain_bank
    import systolic_drain_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned COLS      = DEF_COLS
) (
    input  logic                            clk,
    input  logic                            load,
    input  logic [ROWS*COLS*OUT_WIDTH-1:0]  grid_in,
    input  logic [idx_w(ROWS)-1:0]          row_sel,
    output logic [COLS*OUT_WIDTH-1:0]       row_out_c
);

    localparam int unsigned RW     = COLS * OUT_WIDTH;
    localparam int unsigned RIDX_W = idx_w(ROWS);

    logic [ROWS*RW-1:0] grid_q;

    // Contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk) begin
        if (load) begin
            grid_q <= grid_in;
        end
    end

    always_comb begin
        row_out_c = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (row_sel == RIDX_W'(r)) begin
                row_out_c = grid_q[r*RW +: RW];
            end
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Captures accumulator grid snapshots into a ping-pong buffer and streams them row by row.
module systolic_drain
    import systolic_drain_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned COLS      = DEF_COLS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COLS-1:0]                 stream_out_rdy,
    input  logic [ROWS*COLS*OUT_WIDTH-1:0]  acc_data,
    output logic                            stall,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [COLS*OUT_WIDTH-1:0]       m_data,
    output logic [idx_w(ROWS)-1:0]          m_row,
    output logic                            m_last,
    output logic                            skew_err
);

    localparam int unsigned RW     = COLS * OUT_WIDTH;
    localparam int unsigned RIDX_W = idx_w(ROWS);
    localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);

    rd_state_e          state_q, state_d;
    logic [1:0]         count_q, count_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [RIDX_W-1:0]  row_q, row_d;
    logic               skew_q, skew_d;

    logic               capture_c;
    logic               pop_c;
    logic [RW-1:0]      row0_c, row1_c;

    assign capture_c = stream_out_rdy[0] && (count_q != 2'd2);
    assign pop_c     = (state_q == SEND) && m_ready && (row_q == LAST_ROW);

    systolic_drain_bank #(
        .OUT_WIDTH (OUT_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) u_bank0 (
        .clk       (clk),
        .load      (capture_c && !wr_bank_q),
        .grid_in   (acc_data),
        .row_sel   (row_q),
        .row_out_c (row0_c)
    );

    systolic_drain_bank #(
        .OUT_WIDTH (OUT_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) u_bank1 (
        .clk       (clk),
        .load      (capture_c && wr_bank_q),
        .grid_in   (acc_data),
        .row_sel   (row_q),
        .row_out_c (row1_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 2'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            row_q     <= '0;
            skew_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            row_q     <= row_d;
            skew_q    <= skew_d;
        end
    end

    // Occupancy bookkeeping plus the read FSM; a capture and a final-beat pop may coincide.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        row_d     = row_q;
        skew_d    = skew_q | ((|stream_out_rdy) & ~(&stream_out_rdy));

        if (capture_c) begin
            wr_bank_d = ~wr_bank_q;
        end

        case ({capture_c, pop_c})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                // Looking at the capture directly gives valid on the cycle after the capture edge.
                if ((count_q != 2'd0) || capture_c) begin
                    state_d = SEND;
                    row_d   = '0;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (row_q == LAST_ROW) begin
                        row_d     = '0;
                        rd_bank_d = ~rd_bank_q;
                        if (count_d == 2'd0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        row_d = row_q + RIDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_valid  = (state_q == SEND);
    assign m_row    = row_q;
    assign m_last   = (state_q == SEND) && (row_q == LAST_ROW);
    assign m_data   = rd_bank_q ? row1_c : row0_c;
    assign stall    = (count_q == 2'd2);
    assign skew_err = skew_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed self-checking bench for systolic_drain with hand-computed row contents.
module tb_systolic_drain;
    import systolic_drain_pkg::*;

    localparam int unsigned OW = DEF_OUT_WIDTH;
    localparam int unsigned NR = DEF_ROWS;
    localparam int unsigned NC = DEF_COLS;

    logic                 clk;
    logic                 rst;
    logic [NC-1:0]        stream_out_rdy;
    logic [GRID_W-1:0]    acc_data;
    logic                 stall;
    logic                 m_valid;
    logic                 m_ready;
    logic [ROW_W-1:0]     m_data;
    logic [idx_w(NR)-1:0] m_row;
    logic                 m_last;
    logic                 skew_err;

    int n_cmp;
    int n_bad;

    systolic_drain #(
        .OUT_WIDTH (OW),
        .ROWS      (NR),
        .COLS      (NC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stream_out_rdy (stream_out_rdy),
        .acc_data       (acc_data),
        .stall          (stall),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_row          (m_row),
        .m_last         (m_last),
        .skew_err       (skew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Element (r,c) of a snapshot holds base + r*16 + c.
    function automatic logic [GRID_W-1:0] mk_grid(input int unsigned base);
        logic [GRID_W-1:0] g;
        g = '0;
        for (int r = 0; r < int'(NR); r++)
            for (int c = 0; c < int'(NC); c++)
                g[(r*NC+c)*OW +: OW] = OW'(base + r*16 + c);
        return g;
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int unsigned base, input int unsigned r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int c = 0; c < int'(NC); c++)
            v[c*OW +: OW] = OW'(base + r*16 + c);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int unsigned base, input int unsigned r);
        chk({tag, "_valid"}, 64'(m_valid), 64'(1));
        chk({tag, "_row"},   64'(m_row),   64'(r));
        chk({tag, "_data"},  64'(m_data),  exp_row(base, r));
        chk({tag, "_last"},  64'(m_last),  64'(r == NR - 1));
    endtask

    // Full snapshot at one beat per cycle; optionally release stream_out_rdy after the first edge.
    task automatic drain(input string tag, input int unsigned base, input bit lower_after_first);
        for (int r = 0; r < int'(NR); r++) begin
            beat(tag, base, r);
            tick();
            if (lower_after_first && r == 0) stream_out_rdy = '0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        stream_out_rdy = '0;
        acc_data = '0;
        m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_row",   64'(m_row),   64'(0));
        chk("rst_last",  64'(m_last),  64'(0));
        chk("rst_stall", 64'(stall),   64'(0));
        chk("rst_skew",  64'(skew_err), 64'(0));

        // Single snapshot, values r*16+c.
        m_ready = 1'b1;
        acc_data = mk_grid(0);
        stream_out_rdy = 4'b1111;
        tick();
        stream_out_rdy = '0;
        chk("single_row0_literal", 64'(m_data), 64'h0003_0002_0001_0000);
        for (int r = 0; r < int'(NR); r++) begin
            chk("single_stall", 64'(stall), 64'(0));
            beat("single", 0, r);
            if (r == int'(NR) - 1)
                chk("single_row3_literal", 64'(m_data), 64'h0033_0032_0031_0030);
            tick();
        end
        chk("single_idle", 64'(m_valid), 64'(0));

        // Backpressure on the first beat.
        m_ready = 1'b0;
        acc_data = mk_grid(32'h100);
        stream_out_rdy = 4'b1111;
        tick();
        stream_out_rdy = '0;
        acc_data = '0;
        for (int i = 0; i < 10; i++) begin
            beat("hold", 32'h100, 0);
            tick();
        end
        m_ready = 1'b1;
        drain("bp", 32'h100, 1'b0);
        chk("bp_idle", 64'(m_valid), 64'(0));

        // Fill both banks, hold a third request while stalled.
        m_ready = 1'b0;
        acc_data = mk_grid(32'h200);
        stream_out_rdy = 4'b1111;
        tick();
        chk("fill_stall_after_A", 64'(stall), 64'(0));
        acc_data = mk_grid(32'h300);
        tick();
        chk("fill_stall_after_B", 64'(stall), 64'(1));
        acc_data = mk_grid(32'h400);
        tick();
        tick();
        chk("fill_stall_held", 64'(stall), 64'(1));
        beat("fill_hold_A", 32'h200, 0);
        m_ready = 1'b1;
        for (int r = 0; r < int'(NR); r++) begin
            chk("fill_stall_during_A", 64'(stall), 64'(1));
            beat("A", 32'h200, r);
            tick();
        end
        chk("fill_stall_drop", 64'(stall), 64'(0));
        drain("B", 32'h300, 1'b1);
        drain("C", 32'h400, 1'b0);
        chk("fill_idle", 64'(m_valid), 64'(0));
        chk("fill_stall_end", 64'(stall), 64'(0));

        // Capture on the same edge as the final-beat pop.
        acc_data = mk_grid(32'h500);
        stream_out_rdy = 4'b1111;
        tick();
        stream_out_rdy = '0;
        for (int r = 0; r < int'(NR) - 1; r++) begin
            beat("D", 32'h500, r);
            tick();
        end
        acc_data = mk_grid(32'h600);
        stream_out_rdy = 4'b1111;
        beat("D", 32'h500, NR - 1);
        tick();
        stream_out_rdy = '0;
        chk("simul_stall", 64'(stall), 64'(0));
        drain("E", 32'h600, 1'b0);
        chk("simul_idle", 64'(m_valid), 64'(0));

        // Skewed ready bits: sticky flag, capture from bit 0.
        chk("skew_before", 64'(skew_err), 64'(0));
        acc_data = mk_grid(32'h700);
        stream_out_rdy = 4'b0011;
        tick();
        stream_out_rdy = '0;
        chk("skew_set", 64'(skew_err), 64'(1));
        drain("skew", 32'h700, 1'b0);
        chk("skew_one_capture", 64'(m_valid), 64'(0));
        tick();
        chk("skew_sticky", 64'(skew_err), 64'(1));

        // Reset in the middle of a stream with both banks occupied.
        m_ready = 1'b0;
        acc_data = mk_grid(32'h800);
        stream_out_rdy = 4'b1111;
        tick();
        acc_data = mk_grid(32'h900);
        tick();
        stream_out_rdy = '0;
        m_ready = 1'b1;
        beat("F", 32'h800, 0);
        tick();
        beat("F", 32'h800, 1);
        tick();
        beat("F", 32'h800, 2);
        chk("mrst_stall_before", 64'(stall), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 64'(m_valid), 64'(0));
        chk("mrst_stall", 64'(stall),   64'(0));
        chk("mrst_skew",  64'(skew_err), 64'(0));
        chk("mrst_row",   64'(m_row),   64'(0));
        tick();
        chk("mrst_still_idle", 64'(m_valid), 64'(0));
        acc_data = mk_grid(32'hA00);
        stream_out_rdy = 4'b1111;
        tick();
        stream_out_rdy = '0;
        drain("H", 32'hA00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("mrst_only_H", 64'(m_valid), 64'(0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
